// File: rtl/id_scoreboard_if.sv
// Decode/writeback handshake bundle for the register scoreboard.
interface id_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write_en;
  logic        ex_ready;
  logic        wb_reg_write_en;
  logic [4:0]  wb_rd_addr;
  logic        kill_valid;
  logic [4:0]  kill_rd_addr;
  logic        stall;
  logic        issue;
  logic [31:0] busy_vec;
  logic [2:0]  inflight_cnt;
  logic        sb_err;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_reg_write_en, ex_ready, wb_reg_write_en, wb_rd_addr,
           kill_valid, kill_rd_addr,
    input  stall, issue, busy_vec, inflight_cnt, sb_err
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_reg_write_en, ex_ready, wb_reg_write_en, wb_rd_addr,
           kill_valid, kill_rd_addr,
    output stall, issue, busy_vec, inflight_cnt, sb_err
  );
endinterface

// File: rtl/id_scoreboard.sv
// Register-write scoreboard: per-register pending counters gate issue from ID.
// Optional macro SCOREBOARD_BYPASS_EN lets a source whose last write retires via WB this cycle issue.
module id_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input logic           clk,
    input logic           rst,
    id_scoreboard_if.slave sb
);

    logic [1:0] cnt_q [32];
    logic [1:0] cnt_d [32];
    logic [2:0] inflight_q, inflight_d;
    logic       err_q, err_d;

    logic [1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic       rd_write, rs1_byp, rs2_byp;
    logic       rs1_hz, rs2_hz, waw_hz, cap_hz;
    logic       stall, issue;

    assign rs1_cnt  = cnt_q[sb.id_rs1_addr];
    assign rs2_cnt  = cnt_q[sb.id_rs2_addr];
    assign rd_cnt   = cnt_q[sb.id_rd_addr];
    assign rd_write = sb.id_reg_write_en && (sb.id_rd_addr != 5'd0);

`ifdef SCOREBOARD_BYPASS_EN
    // Only a WB retire of the last pending write counts; the register file writes through.
    assign rs1_byp = (rs1_cnt == 2'd1) && sb.wb_reg_write_en && (sb.wb_rd_addr == sb.id_rs1_addr);
    assign rs2_byp = (rs2_cnt == 2'd1) && sb.wb_reg_write_en && (sb.wb_rd_addr == sb.id_rs2_addr);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    always_comb begin
        rs1_hz = sb.id_rs1_used && (sb.id_rs1_addr != 5'd0) && (rs1_cnt != 2'd0) && !rs1_byp;
        rs2_hz = sb.id_rs2_used && (sb.id_rs2_addr != 5'd0) && (rs2_cnt != 2'd0) && !rs2_byp;
        waw_hz = rd_write && (rd_cnt == 2'd3);
        cap_hz = rd_write && (inflight_q == 3'(MAX_INFLIGHT));
        stall  = sb.id_valid && (rs1_hz || rs2_hz || waw_hz || cap_hz);
        issue  = sb.id_valid && !stall && sb.ex_ready;
    end

    // Retires against an empty counter are dropped individually and flagged.
    always_comb begin
        logic       inc, wb_hit, kill_hit;
        logic [1:0] ndec, eff;
        logic [2:0] dec_total;
        cnt_d     = cnt_q;
        cnt_d[0]  = 2'd0;
        err_d     = err_q;
        dec_total = 3'd0;
        for (int unsigned n = 1; n < 32; n++) begin
            inc      = issue && rd_write && (sb.id_rd_addr == 5'(n));
            wb_hit   = sb.wb_reg_write_en && (sb.wb_rd_addr == 5'(n));
            kill_hit = sb.kill_valid && (sb.kill_rd_addr == 5'(n));
            ndec     = {1'b0, wb_hit} + {1'b0, kill_hit};
            eff      = (ndec > cnt_q[n]) ? cnt_q[n] : ndec;
            if (ndec > cnt_q[n]) err_d = 1'b1;
            cnt_d[n]  = cnt_q[n] + {1'b0, inc} - eff;
            dec_total = dec_total + {1'b0, eff};
        end
        inflight_d = inflight_q + {2'b0, (issue && rd_write)} - dec_total;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned n = 0; n < 32; n++) cnt_q[n] <= 2'd0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < 32; n++) sb.busy_vec[n] = (cnt_q[n] != 2'd0);
    end

    assign sb.stall        = stall;
    assign sb.issue        = issue;
    assign sb.inflight_cnt = inflight_q;
    assign sb.sb_err       = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench: stimulus queues expected outputs per cycle, a negedge monitor pops and checks.
module tb_id_scoreboard;

  typedef struct {
    string       name;
    logic        stall;
    logic        issue;
    logic [31:0] busy;
    logic [2:0]  infl;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  id_scoreboard_if sb ();

  id_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (sb.stall !== e.stall || sb.issue !== e.issue || sb.busy_vec !== e.busy ||
          sb.inflight_cnt !== e.infl || sb.sb_err !== e.err) begin
        bad++;
        $display("FAIL %s: got stall=%b issue=%b busy=%h infl=%0d err=%b, want stall=%b issue=%b busy=%h infl=%0d err=%b",
                 e.name, sb.stall, sb.issue, sb.busy_vec, sb.inflight_cnt, sb.sb_err,
                 e.stall, e.issue, e.busy, e.infl, e.err);
      end
    end
  end

  task automatic idle();
    sb.id_valid = 0; sb.id_rs1_addr = 0; sb.id_rs2_addr = 0;
    sb.id_rs1_used = 0; sb.id_rs2_used = 0; sb.id_rd_addr = 0;
    sb.id_reg_write_en = 0; sb.ex_ready = 1; sb.wb_reg_write_en = 0;
    sb.wb_rd_addr = 0; sb.kill_valid = 0; sb.kill_rd_addr = 0;
  endtask

  task automatic writer(input logic [4:0] rd);
    sb.id_valid = 1; sb.id_rd_addr = rd; sb.id_reg_write_en = 1;
  endtask

  task automatic reader(input logic [4:0] rs1, input logic [4:0] rs2);
    sb.id_valid = 1;
    sb.id_rs1_addr = rs1; sb.id_rs1_used = (rs1 != 0);
    sb.id_rs2_addr = rs2; sb.id_rs2_used = (rs2 != 0);
  endtask

  task automatic wb(input logic [4:0] rd);
    sb.wb_reg_write_en = 1; sb.wb_rd_addr = rd;
  endtask

  task automatic kill(input logic [4:0] rd);
    sb.kill_valid = 1; sb.kill_rd_addr = rd;
  endtask

  task automatic expect_now(input string name, input logic st, input logic is,
                            input logic [31:0] bv, input logic [2:0] ic, input logic er);
    exp_t e;
    e.name = name; e.stall = st; e.issue = is; e.busy = bv; e.infl = ic; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    idle();
    @(posedge clk); #1;
    expect_now("reset_state", 0, 0, 32'h0, 0, 0);
    next();
    rst = 1;

    writer(5);                     expect_now("addi_x5", 0, 1, 32'h0, 0, 0);            next();
    reader(5, 0);                  expect_now("raw_x5", 1, 0, 32'h20, 1, 0);            next();
    reader(5, 0); wb(5);
`ifdef SCOREBOARD_BYPASS_EN
    expect_now("raw_x5_wb", 0, 1, 32'h20, 1, 0);
`else
    expect_now("raw_x5_wb", 1, 0, 32'h20, 1, 0);
`endif
    next();
    reader(5, 0);                  expect_now("raw_x5_clear", 0, 1, 32'h0, 0, 0);       next();

    writer(1);                     expect_now("cap_w1", 0, 1, 32'h0, 0, 0);             next();
    writer(2);                     expect_now("cap_w2", 0, 1, 32'h2, 1, 0);             next();
    writer(3);                     expect_now("cap_w3", 0, 1, 32'h6, 2, 0);             next();
    writer(4);                     expect_now("cap_w4", 0, 1, 32'he, 3, 0);             next();
    writer(6);                     expect_now("cap_full", 1, 0, 32'h1e, 4, 0);          next();
    writer(6); wb(1);              expect_now("cap_no_credit", 1, 0, 32'h1e, 4, 0);     next();
    writer(6);                     expect_now("cap_after_ret", 0, 1, 32'h1c, 3, 0);     next();
    wb(2); kill(3);                expect_now("dual_retire", 0, 0, 32'h5c, 4, 0);       next();
    writer(8); sb.ex_ready = 0;    expect_now("ex_not_ready", 0, 0, 32'h50, 2, 0);      next();
    wb(4); kill(6);                expect_now("drain", 0, 0, 32'h50, 2, 0);             next();

    writer(7);                     expect_now("waw_w1", 0, 1, 32'h0, 0, 0);             next();
    writer(7);                     expect_now("waw_w2", 0, 1, 32'h80, 1, 0);            next();
    writer(7);                     expect_now("waw_w3", 0, 1, 32'h80, 2, 0);            next();
    writer(7);                     expect_now("waw_full", 1, 0, 32'h80, 3, 0);          next();
    writer(7); wb(7);              expect_now("waw_full_ret", 1, 0, 32'h80, 3, 0);      next();
    writer(7);                     expect_now("waw_issue", 0, 1, 32'h80, 2, 0);         next();
    wb(7); kill(7);                expect_now("same_reg_dec2", 0, 0, 32'h80, 3, 0);     next();
    writer(7); wb(7);              expect_now("issue_and_ret", 0, 1, 32'h80, 1, 0);     next();
    wb(7);                         expect_now("net_zero_held", 0, 0, 32'h80, 1, 0);     next();

    writer(5);                     expect_now("x7_drained", 0, 1, 32'h0, 0, 0);         next();
    reader(0, 5); kill(5);         expect_now("kill_no_bypass", 1, 0, 32'h20, 1, 0);    next();
    reader(0, 5);                  expect_now("rs2_clear", 0, 1, 32'h0, 0, 0);          next();

    writer(0); reader(0, 0); sb.id_rs1_used = 1;
                                   expect_now("x0_ignored", 0, 1, 32'h0, 0, 0);         next();
    wb(9);                         expect_now("x0_no_state", 0, 0, 32'h0, 0, 0);        next();
    expect_now("underflow_err", 0, 0, 32'h0, 0, 1);                                     next();
    writer(10);                    expect_now("err_sticky", 0, 1, 32'h0, 0, 1);         next();
    rst = 0; reader(10, 0);        expect_now("async_reset", 0, 1, 32'h0, 0, 0);        next();
    rst = 1;                       expect_now("after_reset", 0, 0, 32'h0, 0, 0);        next();

    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
